// File: rtl/pocket_event_scheduler.sv
// pocket_event_scheduler: sequences shot, pocket and turn events for a two-player pool table.
// Define FOUL_PENALTY_EN to make potting the white ball also pulse decreaseScore.
module pocket_event_scheduler #(
    parameter int NUM_BALLS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 shotFired,
    input  logic                 ballsStopped,
    input  logic [NUM_BALLS-1:0] pocketHit,
    output logic [1:0]           increaseScore,
    output logic [1:0]           decreaseScore,
    output logic                 currentPlayer,
    output logic                 foul,
    output logic                 busy,
    output logic                 gameOver
);
    localparam int CW = $clog2(NUM_BALLS) + 1 < 3 ? 3 : $clog2(NUM_BALLS) + 1;

    typedef enum logic [2:0] {IDLE, ROLLING, DRAIN, TURN_END, GAME_OVER} state_t;

    state_t               state;
    logic [NUM_BALLS-1:0] pending, ballsOut, served, newHits, pendingNext;
    logic [CW-1:0]        pottedCount;
    logic                 scoredThisShot, foulThisShot, rollEntry;
    logic [1:0]           playerMask;

    // served is the one-hot lowest pending ball; a hit on it this cycle must not re-arm it
    always_comb begin
        served      = state == DRAIN ? pending & (~pending + NUM_BALLS'(1)) : '0;
        newHits     = pocketHit & ~ballsOut & ~served;
        pendingNext = (pending & ~served) | newHits;
        playerMask  = {currentPlayer, ~currentPlayer};
    end

    assign busy     = state != IDLE && state != GAME_OVER;
    assign gameOver = state == GAME_OVER;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            pending        <= '0;
            ballsOut       <= '0;
            pottedCount    <= '0;
            scoredThisShot <= 1'b0;
            foulThisShot   <= 1'b0;
            rollEntry      <= 1'b0;
            currentPlayer  <= 1'b0;
            foul           <= 1'b0;
            increaseScore  <= '0;
        end else begin
            increaseScore <= '0;
            if (state != GAME_OVER)
                pending <= pendingNext;
            case (state)
                IDLE: if (shotFired) begin
                    state     <= ROLLING;
                    rollEntry <= 1'b1;
                    foul      <= 1'b0;
                end
                ROLLING: begin
                    rollEntry <= 1'b0;
                    if (ballsStopped && !rollEntry)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (served[0]) begin
                        foul         <= 1'b1;
                        foulThisShot <= 1'b1;
                    end
                    if (|served[NUM_BALLS-1:1]) begin
                        increaseScore  <= playerMask;
                        ballsOut       <= ballsOut | served;
                        pottedCount    <= pottedCount + CW'(1);
                        scoredThisShot <= 1'b1;
                    end
                    if (pendingNext == '0)
                        state <= TURN_END;
                end
                TURN_END: begin
                    if (!scoredThisShot || foulThisShot)
                        currentPlayer <= ~currentPlayer;
                    scoredThisShot <= 1'b0;
                    foulThisShot   <= 1'b0;
                    state          <= pottedCount == CW'(NUM_BALLS - 1) ? GAME_OVER : IDLE;
                end
                GAME_OVER: state <= GAME_OVER;
                default:   state <= IDLE;
            endcase
        end
    end

`ifdef FOUL_PENALTY_EN
    always_ff @(posedge clk) begin
        if (reset)
            decreaseScore <= '0;
        else
            decreaseScore <= served[0] ? playerMask : 2'b00;
    end
`else
    assign decreaseScore = 2'b00;
`endif

endmodule

// File: tb/tb_pocket_event_scheduler.sv
// tb_pocket_event_scheduler: directed and randomized shots checked against a per-shot set model of the table.
module tb_pocket_event_scheduler;
    logic       clk = 1'b0, reset = 1'b1, shotFired = 1'b0, ballsStopped = 1'b0;
    logic [7:0] pocketHit = '0;
    logic [1:0] increaseScore, decreaseScore;
    logic       currentPlayer, foul, busy, gameOver;

    always #5 clk = ~clk;

    pocket_event_scheduler #(.NUM_BALLS(8)) dut (
        .clk(clk), .reset(reset), .shotFired(shotFired), .ballsStopped(ballsStopped),
        .pocketHit(pocketHit), .increaseScore(increaseScore), .decreaseScore(decreaseScore),
        .currentPlayer(currentPlayer), .foul(foul), .busy(busy), .gameOver(gameOver)
    );

    int checks = 0, errors = 0;
    int cyc = 0, inc0 = 0, inc1 = 0, dec0 = 0, dec1 = 0, bad = 0, lastInc = 0, prevInc = 0;

    logic [7:0] outM;
    int         pottedM;
    logic       playerM, foulM, overM;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (increaseScore[0]) inc0 <= inc0 + 1;
        if (increaseScore[1]) inc1 <= inc1 + 1;
        if (decreaseScore[0]) dec0 <= dec0 + 1;
        if (decreaseScore[1]) dec1 <= dec1 + 1;
        if (|increaseScore) begin
            prevInc <= lastInc;
            lastInc <= cyc;
        end
        if ($countones({increaseScore, decreaseScore}) > 1) bad <= bad + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic resetModel;
        outM = '0; pottedM = 0; playerM = 1'b0; foulM = 1'b0; overM = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".over"}, gameOver, 0);
        check({tag, ".player"}, currentPlayer, 0);
        check({tag, ".foul"}, foul, 0);
        check({tag, ".inc"}, increaseScore, 0);
        check({tag, ".dec"}, decreaseScore, 0);
        check({tag, ".potted"}, dut.pottedCount, 0);
    endtask

    task automatic doReset;
        reset = 1'b1; shotFired = 1'b0; ballsStopped = 1'b0; pocketHit = '0;
        tick; tick;
        reset = 1'b0;
        resetModel;
        checkIdle("rst");
    endtask

    task automatic startShot(input logic [7:0] h0, input logic [7:0] h1);
        ballsStopped = 1'b0;
        shotFired = 1'b1;
        tick;
        shotFired = 1'b0;
        pocketHit = h0;
        tick;
        pocketHit = h1;
        tick;
        pocketHit = '0;
        ballsStopped = 1'b1;
    endtask

    task automatic finishShot(input logic [7:0] h2, output int n);
        tick;
        pocketHit = h2;
        tick;
        pocketHit = '0;
        n = 2;
        while (busy && n < 20) begin
            tick;
            n++;
        end
    endtask

    task automatic runShot(input logic [7:0] h0, h1, h2, input string tag);
        int i0, i1, d0, d1, b0, n, inc, decExp;
        logic [7:0] hits, newObj;
        logic white, p;
        i0 = inc0; i1 = inc1; d0 = dec0; d1 = dec1; b0 = bad;
        startShot(h0, h1);
        finishShot(h2, n);
        check({tag, ".tmo"}, int'(n < 20), 1);
        hits   = h0 | h1 | h2;
        newObj = overM ? 8'h00 : hits & ~outM & 8'hFE;
        white  = !overM && hits[0];
        inc    = $countones(newObj);
        p      = playerM;
`ifdef FOUL_PENALTY_EN
        decExp = int'(white);
`else
        decExp = 0;
`endif
        check({tag, ".inc"}, p ? inc1 - i1 : inc0 - i0, inc);
        check({tag, ".incOther"}, p ? inc0 - i0 : inc1 - i1, 0);
        check({tag, ".dec"}, p ? dec1 - d1 : dec0 - d0, decExp);
        check({tag, ".decOther"}, p ? dec0 - d0 : dec1 - d1, 0);
        check({tag, ".excl"}, bad - b0, 0);
        if (!overM) begin
            if (hits == 8'h00) check({tag, ".lat"}, int'(n <= 3), 1);
            foulM   = white;
            outM    = outM | newObj;
            pottedM = pottedM + inc;
            if (inc == 0 || white) playerM = ~playerM;
            overM   = pottedM == 7;
        end
        check({tag, ".foul"}, foul, foulM);
        check({tag, ".player"}, currentPlayer, playerM);
        check({tag, ".gameOver"}, gameOver, overM);
        check({tag, ".potted"}, dut.pottedCount, pottedM);
        check({tag, ".busy"}, busy, 0);
    endtask

    function automatic logic [7:0] rndHits(input int pct);
        logic [7:0] v;
        for (int i = 0; i < 8; i++)
            v[i] = $urandom_range(0, 99) < (i == 0 ? pct / 3 : pct);
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int s0;
        doReset;
        runShot(8'b0000_0110, 8'h00, 8'h00, "twoBalls");
        check("twoBalls.adjacent", lastInc - prevInc, 1);
        runShot(8'b0000_0001, 8'h00, 8'h00, "white");
        runShot(8'h00, 8'h00, 8'h00, "noPocket");
        runShot(8'b0000_1000, 8'h00, 8'h00, "ball3");
        runShot(8'h00, 8'b0000_1000, 8'h00, "ball3Again");
        runShot(8'h00, 8'h00, 8'b0001_0000, "hitInDrain");
        runShot(8'b1110_0000, 8'h00, 8'h00, "lastBalls");
        runShot(8'hFF, 8'hFF, 8'hFF, "afterOver");

        doReset;
        startShot(8'b0000_1110, 8'h00);
        tick;
        check("midDrain.busy", busy, 1);
        s0 = inc0 + inc1 + dec0 + dec1;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        ballsStopped = 1'b0;
        resetModel;
        checkIdle("midDrain");
        tick;
        check("midDrain.noPulse", inc0 + inc1 + dec0 + dec1 - s0, 0);
        runShot(8'h00, 8'h00, 8'h00, "afterDrainReset");

        for (int g = 0; g < 5; g++) begin
            doReset;
            for (int s = 0; s < 80 && !overM; s++)
                runShot(rndHits(8), rndHits(8), rndHits(4), $sformatf("g%0ds%0d", g, s));
            runShot(rndHits(50), rndHits(50), rndHits(50), $sformatf("g%0dpost", g));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
